// File: rtl/mastermind_scorer.sv
// mastermind_scorer
// Parametrised Mastermind game engine. It accepts a secret code and then
// guesses over valid/ready handshakes. Each guess is scored one peg per
// clock, with correct handling of repeated colours. The engine counts
// guesses and declares a win or a loss.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   new_game     one-cycle pulse: abort and wait for a new code
//   code_valid   code_in is valid (accepted in WAIT_CODE / GAME_OVER)
//   code_in      secret code, peg i at [i*COLOR_W +: COLOR_W]
//   code_ready   high in WAIT_CODE and GAME_OVER
//   guess_valid  guess_in is valid (accepted in WAIT_GUESS)
//   guess_in     guess, same packing as code_in
//   guess_ready  high in WAIT_GUESS
//   result_valid one-cycle pulse when red/white are updated
//   red          right colour in right position
//   white        right colour in wrong position
//   guess_count  guesses scored in the current game (saturating)
//   win, lose    sticky game outcome, cleared by a new game
module mastermind_scorer #(
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8,
  localparam int CNT_W = $clog2(NUM_PEGS + 1),
  localparam int GC_W  = $clog2(MAX_GUESSES + 1),
  localparam int VEC_W = NUM_PEGS * COLOR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             code_valid,
  input  logic [VEC_W-1:0] code_in,
  output logic             code_ready,
  input  logic             guess_valid,
  input  logic [VEC_W-1:0] guess_in,
  output logic             guess_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] white,
  output logic [GC_W-1:0]  guess_count,
  output logic             win,
  output logic             lose
);

  localparam int IDX_W = $clog2(NUM_PEGS);

  typedef enum logic [2:0] {
    S_WAIT_CODE,
    S_WAIT_GUESS,
    S_SCORE_RED,
    S_SCORE_WHITE,
    S_RESULT,
    S_GAME_OVER
  } state_t;

  state_t state_reg, state_next;

  logic [VEC_W-1:0]    code_reg, guess_reg;
  logic [NUM_PEGS-1:0] code_used_reg, guess_used_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    red_acc_reg, white_acc_reg;
  logic [CNT_W-1:0]    red_reg, white_reg;
  logic [GC_W-1:0]     guess_count_reg;
  logic                result_valid_reg, win_reg, lose_reg;

  // Peg views of the latched code and guess.
  logic [COLOR_W-1:0] code_pegs  [NUM_PEGS];
  logic [COLOR_W-1:0] guess_pegs [NUM_PEGS];
  logic [NUM_PEGS-1:0] white_hit;
  logic [COLOR_W-1:0] code_cur, guess_cur;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PEGS; gi++) begin : g_pegs
      assign code_pegs[gi]  = code_reg[gi*COLOR_W +: COLOR_W];
      assign guess_pegs[gi] = guess_reg[gi*COLOR_W +: COLOR_W];
      // Candidate guess pegs for a white match against the current code peg.
      assign white_hit[gi]  = !guess_used_reg[gi] && (guess_pegs[gi] == code_cur);
    end
  endgenerate

  assign code_cur  = code_pegs[idx_reg];
  assign guess_cur = guess_pegs[idx_reg];

  // Lowest-index free matching guess peg; scanning downward leaves the lowest.
  logic             white_found;
  logic [IDX_W-1:0] white_j;
  always_comb begin
    white_found = 1'b0;
    white_j     = '0;
    for (int j = NUM_PEGS - 1; j >= 0; j--) begin
      if (white_hit[j]) begin
        white_found = 1'b1;
        white_j     = IDX_W'(j);
      end
    end
  end

  logic             last_peg;
  logic [GC_W-1:0]  guess_count_inc;
  logic             all_red;

  assign last_peg        = (idx_reg == IDX_W'(NUM_PEGS - 1));
  assign all_red         = (red_acc_reg == CNT_W'(NUM_PEGS));
  assign guess_count_inc = (guess_count_reg == GC_W'(MAX_GUESSES)) ?
                           guess_count_reg : guess_count_reg + GC_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_WAIT_CODE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (new_game) begin
      state_next = S_WAIT_CODE;
    end else begin
      case (state_reg)
        S_WAIT_CODE:   if (code_valid) state_next = S_WAIT_GUESS;
        S_WAIT_GUESS:  if (guess_valid) state_next = S_SCORE_RED;
        S_SCORE_RED:   if (last_peg) state_next = S_SCORE_WHITE;
        S_SCORE_WHITE: if (last_peg) state_next = S_RESULT;
        S_RESULT: begin
          if (all_red)                                      state_next = S_GAME_OVER;
          else if (guess_count_inc == GC_W'(MAX_GUESSES))   state_next = S_GAME_OVER;
          else                                              state_next = S_WAIT_GUESS;
        end
        S_GAME_OVER:   if (code_valid) state_next = S_WAIT_GUESS;
        default:       state_next = S_WAIT_CODE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      code_reg         <= '0;
      guess_reg        <= '0;
      code_used_reg    <= '0;
      guess_used_reg   <= '0;
      idx_reg          <= '0;
      red_acc_reg      <= '0;
      white_acc_reg    <= '0;
      red_reg          <= '0;
      white_reg        <= '0;
      guess_count_reg  <= '0;
      result_valid_reg <= 1'b0;
      win_reg          <= 1'b0;
      lose_reg         <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      if (new_game) begin
        red_reg         <= '0;
        white_reg       <= '0;
        guess_count_reg <= '0;
        win_reg         <= 1'b0;
        lose_reg        <= 1'b0;
      end else begin
        case (state_reg)
          S_WAIT_CODE: begin
            if (code_valid) code_reg <= code_in;
          end
          S_WAIT_GUESS: begin
            if (guess_valid) begin
              guess_reg      <= guess_in;
              code_used_reg  <= '0;
              guess_used_reg <= '0;
              red_acc_reg    <= '0;
              white_acc_reg  <= '0;
              idx_reg        <= '0;
            end
          end
          S_SCORE_RED: begin
            if (code_cur == guess_cur) begin
              red_acc_reg             <= red_acc_reg + CNT_W'(1);
              code_used_reg[idx_reg]  <= 1'b1;
              guess_used_reg[idx_reg] <= 1'b1;
            end
            idx_reg <= last_peg ? '0 : idx_reg + IDX_W'(1);
          end
          S_SCORE_WHITE: begin
            // Code pegs already matched as red do not take part.
            if (!code_used_reg[idx_reg] && white_found) begin
              guess_used_reg[white_j] <= 1'b1;
              white_acc_reg           <= white_acc_reg + CNT_W'(1);
            end
            idx_reg <= last_peg ? '0 : idx_reg + IDX_W'(1);
          end
          S_RESULT: begin
            result_valid_reg <= 1'b1;
            red_reg          <= red_acc_reg;
            white_reg        <= white_acc_reg;
            guess_count_reg  <= guess_count_inc;
            // A win on the final guess takes precedence over a loss.
            if (all_red)                                    win_reg  <= 1'b1;
            else if (guess_count_inc == GC_W'(MAX_GUESSES)) lose_reg <= 1'b1;
          end
          S_GAME_OVER: begin
            if (code_valid) begin
              code_reg        <= code_in;
              red_reg         <= '0;
              white_reg       <= '0;
              guess_count_reg <= '0;
              win_reg         <= 1'b0;
              lose_reg        <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign code_ready   = (state_reg == S_WAIT_CODE) || (state_reg == S_GAME_OVER);
  assign guess_ready  = (state_reg == S_WAIT_GUESS);
  assign result_valid = result_valid_reg;
  assign red          = red_reg;
  assign white        = white_reg;
  assign guess_count  = guess_count_reg;
  assign win          = win_reg;
  assign lose         = lose_reg;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed testbench for mastermind_scorer: default 4-peg instance plus a
// 6-peg / 4-bit / 10-guess instance.
module tb_mastermind_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (4 pegs, 3 bits, 8 guesses)
  logic        reset_a = 1'b1, new_game_a = 1'b0;
  logic        code_valid_a = 1'b0, guess_valid_a = 1'b0;
  logic [11:0] code_in_a = '0, guess_in_a = '0;
  logic        code_ready_a, guess_ready_a, result_valid_a, win_a, lose_a;
  logic [2:0]  red_a, white_a;
  logic [3:0]  guess_count_a;

  mastermind_scorer dut_a (
    .clk(clk), .reset(reset_a), .new_game(new_game_a),
    .code_valid(code_valid_a), .code_in(code_in_a), .code_ready(code_ready_a),
    .guess_valid(guess_valid_a), .guess_in(guess_in_a), .guess_ready(guess_ready_a),
    .result_valid(result_valid_a), .red(red_a), .white(white_a),
    .guess_count(guess_count_a), .win(win_a), .lose(lose_a)
  );

  // Instance B: 6 pegs, 4 bits, 10 guesses
  logic        reset_b = 1'b1, new_game_b = 1'b0;
  logic        code_valid_b = 1'b0, guess_valid_b = 1'b0;
  logic [23:0] code_in_b = '0, guess_in_b = '0;
  logic        code_ready_b, guess_ready_b, result_valid_b, win_b, lose_b;
  logic [2:0]  red_b, white_b;
  logic [3:0]  guess_count_b;

  mastermind_scorer #(.NUM_PEGS(6), .COLOR_W(4), .MAX_GUESSES(10)) dut_b (
    .clk(clk), .reset(reset_b), .new_game(new_game_b),
    .code_valid(code_valid_b), .code_in(code_in_b), .code_ready(code_ready_b),
    .guess_valid(guess_valid_b), .guess_in(guess_in_b), .guess_ready(guess_ready_b),
    .result_valid(result_valid_b), .red(red_b), .white(white_b),
    .guess_count(guess_count_b), .win(win_b), .lose(lose_b)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [11:0] pk4(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  function automatic logic [23:0] pk6(input int p0, input int p1, input int p2,
                                      input int p3, input int p4, input int p5);
    return {4'(p5), 4'(p4), 4'(p3), 4'(p2), 4'(p1), 4'(p0)};
  endfunction

  task automatic load_a(input logic [11:0] c);
    @(negedge clk); code_in_a = c; code_valid_a = 1'b1;
    @(negedge clk); code_valid_a = 1'b0; code_in_a = ~c;
  endtask

  task automatic pulse_new_game_a();
    @(negedge clk); new_game_a = 1'b1;
    @(negedge clk); new_game_a = 1'b0;
  endtask

  // Offers a guess and returns at the negedge where result_valid is seen;
  // lat is the number of clocks after the accept edge (bounded).
  task automatic play_a(input logic [11:0] g, output int lat);
    @(negedge clk); guess_in_a = g; guess_valid_a = 1'b1;
    @(negedge clk); guess_valid_a = 1'b0; guess_in_a = ~g;
    lat = 0;
    while (!result_valid_a && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  // Counts result_valid pulses over n cycles.
  task automatic watch_a(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (result_valid_a) pulses++;
    end
  endtask

  int lat, pulses;

  initial begin
    // ---- Reset values ----
    repeat (2) @(negedge clk);
    chk("rst_code_ready", 32'(code_ready_a), 1);
    chk("rst_guess_ready", 32'(guess_ready_a), 0);
    chk("rst_result_valid", 32'(result_valid_a), 0);
    chk("rst_red", 32'(red_a), 0);
    chk("rst_white", 32'(white_a), 0);
    chk("rst_guess_count", 32'(guess_count_a), 0);
    chk("rst_win", 32'(win_a), 0);
    chk("rst_lose", 32'(lose_a), 0);
    reset_a = 1'b0;

    // ---- Straight win ----
    load_a(pk4(1, 2, 3, 4));
    chk("load_guess_ready", 32'(guess_ready_a), 1);
    chk("load_code_ready", 32'(code_ready_a), 0);
    play_a(pk4(1, 2, 3, 4), lat);
    $display("guess 1,2,3,4 vs 1,2,3,4: lat=%0d red=%0d white=%0d", lat, red_a, white_a);
    chk("win_latency", 32'(lat), 9);
    chk("win_red", 32'(red_a), 4);
    chk("win_white", 32'(white_a), 0);
    chk("win_flag", 32'(win_a), 1);
    chk("win_count", 32'(guess_count_a), 1);
    chk("win_code_ready", 32'(code_ready_a), 1);
    chk("win_guess_ready", 32'(guess_ready_a), 0);
    @(negedge clk);
    chk("rv_single_pulse", 32'(result_valid_a), 0);

    // ---- Duplicate handling ----
    load_a(pk4(1, 1, 2, 2));  // from GAME_OVER: clears outcome
    chk("reload_win_clear", 32'(win_a), 0);
    chk("reload_count_clear", 32'(guess_count_a), 0);
    play_a(pk4(2, 2, 1, 1), lat);
    $display("guess 2,2,1,1 vs 1,1,2,2: red=%0d white=%0d", red_a, white_a);
    chk("dup1_red", 32'(red_a), 0);
    chk("dup1_white", 32'(white_a), 4);

    pulse_new_game_a();
    load_a(pk4(1, 1, 2, 3));
    play_a(pk4(1, 3, 1, 1), lat);
    $display("guess 1,3,1,1 vs 1,1,2,3: red=%0d white=%0d", red_a, white_a);
    chk("dup2_red", 32'(red_a), 1);
    chk("dup2_white", 32'(white_a), 2);

    pulse_new_game_a();
    load_a(pk4(5, 5, 5, 5));
    play_a(pk4(5, 0, 0, 5), lat);
    $display("guess 5,0,0,5 vs 5,5,5,5: red=%0d white=%0d", red_a, white_a);
    chk("dup3_red", 32'(red_a), 2);
    chk("dup3_white", 32'(white_a), 0);
    chk("dup3_count", 32'(guess_count_a), 1);

    // ---- Loss after 8 guesses ----
    pulse_new_game_a();
    load_a(pk4(1, 2, 3, 4));
    for (int n = 1; n <= 8; n++) begin
      play_a(pk4(0, 0, 0, 0), lat);
      $display("loss guess %0d: red=%0d white=%0d count=%0d", n, red_a, white_a, guess_count_a);
      chk("loss_red", 32'(red_a), 0);
      chk("loss_white", 32'(white_a), 0);
      chk("loss_count", 32'(guess_count_a), 32'(n));
    end
    chk("loss_lose", 32'(lose_a), 1);
    chk("loss_win", 32'(win_a), 0);
    @(negedge clk);
    chk("loss_guess_ready", 32'(guess_ready_a), 0);
    guess_in_a = pk4(1, 2, 3, 4); guess_valid_a = 1'b1;
    watch_a(15, pulses);
    guess_valid_a = 1'b0;
    $display("ninth guess after loss: pulses=%0d count=%0d", pulses, guess_count_a);
    chk("ninth_ignored", 32'(pulses), 0);
    chk("ninth_count", 32'(guess_count_a), 8);

    // ---- Win on final guess ----
    load_a(pk4(1, 2, 3, 4));
    chk("restart_lose_clear", 32'(lose_a), 0);
    for (int n = 1; n <= 7; n++) play_a(pk4(4, 3, 2, 1), lat);
    chk("last_pre_white", 32'(white_a), 4);
    chk("last_pre_lose", 32'(lose_a), 0);
    play_a(pk4(1, 2, 3, 4), lat);
    $display("final-guess win: win=%0d lose=%0d count=%0d", win_a, lose_a, guess_count_a);
    chk("last_win", 32'(win_a), 1);
    chk("last_lose", 32'(lose_a), 0);
    chk("last_count", 32'(guess_count_a), 8);

    // ---- Abort with new_game during SCORE_RED ----
    pulse_new_game_a();
    load_a(pk4(1, 2, 3, 4));
    play_a(pk4(1, 2, 0, 0), lat);
    chk("pre_abort_red", 32'(red_a), 2);
    @(negedge clk); guess_in_a = pk4(1, 2, 3, 4); guess_valid_a = 1'b1;
    @(negedge clk); guess_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    new_game_a = 1'b1;
    @(negedge clk); new_game_a = 1'b0;
    chk("abort_code_ready", 32'(code_ready_a), 1);
    chk("abort_guess_ready", 32'(guess_ready_a), 0);
    chk("abort_red", 32'(red_a), 0);
    chk("abort_count", 32'(guess_count_a), 0);
    watch_a(15, pulses);
    $display("abort in SCORE_RED: pulses=%0d", pulses);
    chk("abort_no_result", 32'(pulses), 0);
    chk("abort_win", 32'(win_a), 0);

    // ---- Reset during SCORE_WHITE ----
    load_a(pk4(1, 2, 3, 4));
    play_a(pk4(1, 0, 0, 0), lat);
    chk("pre_reset_count", 32'(guess_count_a), 1);
    @(negedge clk); guess_in_a = pk4(1, 2, 3, 4); guess_valid_a = 1'b1;
    @(negedge clk); guess_valid_a = 1'b0;
    repeat (5) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    $display("reset in SCORE_WHITE: red=%0d count=%0d code_ready=%0d", red_a, guess_count_a, code_ready_a);
    chk("wrst_code_ready", 32'(code_ready_a), 1);
    chk("wrst_guess_ready", 32'(guess_ready_a), 0);
    chk("wrst_red", 32'(red_a), 0);
    chk("wrst_count", 32'(guess_count_a), 0);
    chk("wrst_win", 32'(win_a), 0);
    watch_a(15, pulses);
    chk("wrst_no_result", 32'(pulses), 0);

    // ---- Parametric instance ----
    reset_b = 1'b0;
    @(negedge clk); code_in_b = pk6(9, 9, 3, 15, 0, 1); code_valid_b = 1'b1;
    @(negedge clk); code_valid_b = 1'b0; code_in_b = '0;
    chk("b_guess_ready", 32'(guess_ready_b), 1);
    guess_in_b = pk6(9, 3, 9, 1, 15, 7); guess_valid_b = 1'b1;
    @(negedge clk); guess_valid_b = 1'b0; guess_in_b = '1;
    lat = 0;
    while (!result_valid_b && lat < 40) begin
      @(negedge clk); lat++;
    end
    $display("6-peg guess: lat=%0d red=%0d white=%0d", lat, red_b, white_b);
    chk("b_latency", 32'(lat), 13);
    chk("b_red", 32'(red_b), 1);
    chk("b_white", 32'(white_b), 4);
    chk("b_count", 32'(guess_count_b), 1);
    chk("b_win", 32'(win_b), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Parametrised game engine and peg scorer that supersedes the fixed 4-peg, 3-bit compare/control pair.
- Accepts a secret code, then guesses through valid/ready handshakes.
- Scores each guess iteratively with correct duplicate-colour handling, counts guesses, and declares win or lose.
- Sits between the switch/key input logic and the hex display decoders.

Parameters:
- NUM_PEGS, 4, number of peg positions per code/guess (>=2).
- COLOR_W, 3, bits per peg colour.
- MAX_GUESSES, 8, guesses allowed before loss (>=1).
- Derived, not overridable: CNT_W = $clog2(NUM_PEGS+1); GC_W = $clog2(MAX_GUESSES+1); VEC_W = NUM_PEGS*COLOR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  one-cycle pulse: abort and return to WAIT_CODE.
- code_valid  in  1  code_in is valid.
- code_in  in  VEC_W  secret code; peg i at [i*COLOR_W +: COLOR_W].
- code_ready  out  1  high only in WAIT_CODE and GAME_OVER.
- guess_valid  in  1  guess_in is valid.
- guess_in  in  VEC_W  guess; same packing as code_in.
- guess_ready  out  1  high only in WAIT_GUESS.
- result_valid  out  1  one-cycle pulse when red/white are updated.
- red  out  CNT_W  right colour in right position.
- white  out  CNT_W  right colour in wrong position.
- guess_count  out  GC_W  guesses scored in the current game.
- win  out  1  sticky until new game.
- lose  out  1  sticky until new game.

Behaviour:
- One clock domain; synchronous active-high reset.
- Reset values: state=WAIT_CODE; code_ready=1; guess_ready=0; result_valid=0; red=white=0; guess_count=0; win=lose=0; internal code/guess/match registers cleared.
- Priority: reset > new_game > handshake.
- new_game in any state:
  - next state WAIT_CODE;
  - clears red, white, guess_count, win, lose;
  - aborts scoring in progress; no result_valid for it.
- States:
  - WAIT_CODE: code_valid -> latch code_in, go to WAIT_GUESS.
  - WAIT_GUESS: guess_valid -> latch guess_in, clear match masks and counters, peg index i=0, go to SCORE_RED.
  - SCORE_RED: for 1 peg per cycle, i=0..NUM_PEGS-1:
    - if code[i]==guess[i]: red_acc++, set code_used[i] and guess_used[i].
    - After peg NUM_PEGS-1 -> SCORE_WHITE with i=0.
  - SCORE_WHITE: for 1 code peg per cycle, i=0..NUM_PEGS-1, only if !code_used[i]:
    - find the lowest j with !guess_used[j] and guess[j]==code[i];
    - if found: set guess_used[j], white_acc++.
    - The j search is combinational within the cycle.
    - After peg NUM_PEGS-1 -> RESULT.
  - RESULT (1 cycle):
    - result_valid=1; red<=red_acc; white<=white_acc; guess_count++.
    - If red_acc==NUM_PEGS: win=1, go to GAME_OVER.
    - Else if the new guess_count==MAX_GUESSES: lose=1, go to GAME_OVER.
    - Else go to WAIT_GUESS.
  - GAME_OVER: code_valid -> latch code, clear red/white/guess_count/win/lose, go to WAIT_GUESS.
- Latency: result_valid is high in the cycle exactly 2*NUM_PEGS+1 clocks after the guess-accept edge (9 for NUM_PEGS=4).
- Throughput: one guess per 2*NUM_PEGS+2 cycles.
- guess_in and code_in are sampled only on the accept edge; later changes have no effect.
- Inputs not accepted are ignored: guess_valid outside WAIT_GUESS, code_valid outside WAIT_CODE/GAME_OVER.
- red, white, win and lose hold their values between results.
- Invariant: red+white <= NUM_PEGS; accumulators never wrap.
- guess_count saturates at MAX_GUESSES.
- A win on the final guess sets win=1 and lose=0.

Test Plan:
- Defaults. Code pegs (0..3)=1,2,3,4; guess 1,2,3,4 -> result_valid exactly 9 cycles after accept; red=4, white=0, win=1, guess_count=1, code_ready=1, guess_ready=0.
- Duplicates:
  - code 1,1,2,2, guess 2,2,1,1 -> red=0, white=4;
  - code 1,1,2,3, guess 1,3,1,1 -> red=1, white=2;
  - code 5,5,5,5, guess 5,0,0,5 -> red=2, white=0.
- Loss: 8 guesses of 0,0,0,0 against code 1,2,3,4 -> red=white=0 each; after the 8th, guess_count=8, lose=1, win=0, guess_ready=0; a 9th guess_valid is ignored.
- Win on the last guess: 7 wrong guesses, then the correct one -> win=1, lose=0, guess_count=8.
- Abort and reset:
  - new_game pulsed 3 cycles into SCORE_RED -> no result_valid; state WAIT_CODE; counters zero.
  - reset asserted while in SCORE_WHITE -> all outputs return to reset values next cycle.
- Parametric run, NUM_PEGS=6, COLOR_W=4, MAX_GUESSES=10. Code 9,9,3,15,0,1; guess 9,3,9,1,15,7 -> red=1, white=4, result_valid 13 cycles after accept.
